gol_top_module: RTL and testbench
=================================

# gol_top_module

Conway's Game of Life engine for a square toroidal grid of cells, updated one generation per clock. All cells are computed in parallel, so each clock cycle advances the whole grid by one generation. The grid is loaded in one cycle from a flat input vector, and the full state is exposed as a flat output vector. It sits behind a host or testbench that seeds a pattern, then streams or monitors the evolving grid until it stabilises.

## Interface
- `WIDTH`, default 256: total cell count. Must be a perfect square whose side is a power of two.
- `SIDE`, derived as 1 << (clog2(WIDTH)/2), default 16: grid side length. It is a localparam and is not overridable.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `areset`, input, 1: asynchronous, active-high reset.
- `load`, input, 1: synchronous load strobe.
- `d`, input, WIDTH: seed pattern, sampled when `load`=1.
- `q`, output, WIDTH: current grid state.
- `stable`, output, 1: present only with `GOL_STABLE_EN` (see Configuration).

Bit mapping:
- Cell at row r, column c is bit r*SIDE + c of `d` and `q`.
- Bit 0 is row 0, column 0.
- Bit 1 is row 0, column 1, so columns run along the row first.

## Operation
- `q` is a WIDTH-bit register and is the only architectural state.
- Each cell has exactly 8 neighbours (orthogonal and diagonal). Row and column indices wrap modulo SIDE, forming a torus; there is no dead boundary.
- Next state of a cell, given its live-neighbour count n:
  - n = 0 or 1: the cell becomes 0.
  - n = 2: the cell keeps its current value.
  - n = 3: the cell becomes 1.
  - n ≥ 4: the cell becomes 0.
- The neighbour count is 4 bits wide (0..8) and must not overflow.
- All next states are computed from the same registered `q`; the update is a pure combinational function of `q`.
- Per-edge priority:
  - `areset` wins over everything.
  - Otherwise `load`=1 sets `q` ← `d`.
  - Otherwise `q` ← next generation.
- An all-zero grid is a fixed point, and so is any still life.

## Timing
- Reset: `areset` rising clears `q` to 0 immediately, with no clock needed. `stable` also resets to 0.
- While reset is held, `load` and evolution are ignored.
- After release, the first rising edge with `load`=1 captures `d`. With `load`=0, the grid evolves from all-zero and stays zero.
- Load latency: `q` equals `d` one cycle after the `load` edge.
- `load` held for N edges gives N captures of `d`; evolution resumes on the first edge with `load`=0.
- Generation latency: one cycle per generation, with no pipelining and no handshake.
- Reset asserted mid-run clears the grid at once. Evolution restarts only from a new load.

## Configuration
- `GOL_STABLE_EN` defined:
  - Adds the `stable` output and one internal WIDTH-bit register holding the previous `q`.
  - `stable` = 1 when, on the last non-load edge, the next generation equalled the current `q` (the grid did not change).
  - `stable` is cleared on reset and on any load edge.
- `GOL_STABLE_EN` undefined: no `stable` port and no extra register.

## Structure
- Package `gol_pkg` holds:
  - the default `WIDTH` and `SIDE` constants;
  - a function `cell_idx(r, c)` returning ((r mod SIDE)*SIDE + (c mod SIDE));
  - the 4-bit neighbour-count type.
- Sub-module `gol_cell` handles one cell:
  - inputs: the cell's current bit and its 8 neighbour bits;
  - output: the next-state bit, from popcount plus the rule.
- The top level instantiates SIDE×SIDE copies of `gol_cell` in a generate loop with wrapped indexing.

## Test plan
1. **Reset:** assert `areset` mid-run with a random grid → `q` = 0 before the next clock edge; it stays 0 while `load`=0.
2. **Blinker:** load bits {84,85,86} (row 5, columns 4..6).
   - After 1 gen: `q` has bits {69,85,101}.
   - After 2 gens: `q` has bits {84,85,86} again.
3. **Wrap blinker:** load bits {15,0,1} (row 0, columns 15/0/1).
   - After 1 gen: `q` has bits {240,0,16}, showing both the column and the row wrap.
4. **Still lifes:**
   - Block {0,1,16,17} stays unchanged for 16 generations.
   - Corner-wrapped block {0,15,240,255} also stays unchanged for 16 generations.
   - With `GOL_STABLE_EN`, `stable` = 1 from the 2nd cycle after load.
5. **Glider:** load {1,18,32,33,34}. After 64 generations `q` equals the load pattern, returning to the original position via the torus.
6. **Load priority:** hold `load`=1 for 3 edges with a blinker on `d` → `q` remains the horizontal blinker throughout, then oscillates once `load` drops.

Source files
------------

// File: rtl/gol_pkg.sv
// ============================================================================
// Module      : gol_pkg
// Description : Shared constants, neighbour-count type and toroidal index
//               helper for the Game of Life engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gol_pkg;

    localparam int c_gol_width = 256;
    localparam int c_gol_side  = 1 << ($clog2(c_gol_width) / 2);

    // Wide enough for 0..8 live neighbours.
    typedef logic [3:0] nbr_cnt_t;

    function automatic int cell_idx(input int r, input int c, input int side = c_gol_side);
        return (((r % side) + side) % side) * side + (((c % side) + side) % side);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gol_if.sv
// ============================================================================
// Module      : gol_if
// Description : Load/seed/state bundle between host and the Life engine.
//               The stable flag exists only when GOL_STABLE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gol_if #(
    parameter int WIDTH = gol_pkg::c_gol_width
);
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
`ifdef GOL_STABLE_EN
    logic             stable;

    modport master (output load, output d, input  q, input  stable);
    modport slave  (input  load, input  d, output q, output stable);
`else
    modport master (output load, output d, input  q);
    modport slave  (input  load, input  d, output q);
`endif
endinterface

`default_nettype wire

// File: rtl/gol_cell.sv
// ============================================================================
// Module      : gol_cell
// Description : Next-state rule for one cell from its 8 neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gol_cell
    import gol_pkg::*;
(
    input  wire logic       i_cur,
    input  wire logic [7:0] i_nbrs,
    output logic            o_next
);

    nbr_cnt_t w_cnt;

    always_comb begin
        w_cnt = '0;
        for (int k = 0; k < 8; k++) begin
            w_cnt = w_cnt + nbr_cnt_t'(i_nbrs[k]);
        end
    end

    always_comb begin
        case (w_cnt)
            4'd2:    o_next = i_cur;
            4'd3:    o_next = 1'b1;
            default: o_next = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/gol_top_module.sv
// ============================================================================
// Module      : gol_top_module
// Description : Toroidal Game of Life grid, one generation per clock.
//               Optional feature macro: GOL_STABLE_EN (adds stable flag).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gol_top_module
    import gol_pkg::*;
#(
    parameter int WIDTH = c_gol_width
) (
    input  wire logic clk,
    input  wire logic areset,
    gol_if.slave      bus
);

    localparam int SIDE = 1 << ($clog2(WIDTH) / 2);

    logic [WIDTH-1:0] grid_q;
    logic [WIDTH-1:0] grid_d;
    logic [WIDTH-1:0] w_next;

    // Every cell sees the same registered grid; neighbours wrap on both axes.
    for (genvar r = 0; r < SIDE; r++) begin : g_row
        for (genvar c = 0; c < SIDE; c++) begin : g_col
            gol_cell u_cell (
                .i_cur  (grid_q[cell_idx(r, c, SIDE)]),
                .i_nbrs ({grid_q[cell_idx(r - 1, c - 1, SIDE)],
                          grid_q[cell_idx(r - 1, c,     SIDE)],
                          grid_q[cell_idx(r - 1, c + 1, SIDE)],
                          grid_q[cell_idx(r,     c - 1, SIDE)],
                          grid_q[cell_idx(r,     c + 1, SIDE)],
                          grid_q[cell_idx(r + 1, c - 1, SIDE)],
                          grid_q[cell_idx(r + 1, c,     SIDE)],
                          grid_q[cell_idx(r + 1, c + 1, SIDE)]}),
                .o_next (w_next[cell_idx(r, c, SIDE)])
            );
        end
    end

    always_comb begin
        grid_d = bus.load ? bus.d : w_next;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            grid_q <= '0;
        end else begin
            grid_q <= grid_d;
        end
    end

    assign bus.q = grid_q;

`ifdef GOL_STABLE_EN
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;
    logic             arm_q;
    logic             arm_d;

    // arm marks that the last edge was an evolution step, so prev/grid
    // compare a generation against its successor rather than a load.
    always_comb begin
        prev_d = grid_q;
        arm_d  = ~bus.load;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            prev_q <= '0;
            arm_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            arm_q  <= arm_d;
        end
    end

    assign bus.stable = arm_q & (prev_q == grid_q);
`endif

endmodule

`default_nettype wire

// File: tb/tb_gol_top_module.sv
// ============================================================================
// Module      : tb_gol_top_module
// Description : Self-checking bench for gol_top_module (16x16 torus).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gol_top_module;

    localparam int W = 256;
    localparam int S = 16;

    typedef logic [W-1:0] grid_t;

    typedef struct {
        string name;
        grid_t seed;
        int    gens;
        grid_t expected;
    } vec_t;

    logic clk    = 1'b0;
    logic areset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    gol_if #(.WIDTH(W)) bus ();

    gol_top_module #(.WIDTH(W)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic grid_t mk(input int a, input int b, input int c,
                                 input int e, input int f);
        grid_t g;
        int    ids[5];
        g   = '0;
        ids = '{a, b, c, e, f};
        foreach (ids[i]) if (ids[i] >= 0) g[ids[i]] = 1'b1;
        return g;
    endfunction

    // Reference: count neighbours on a wrapped 2-D grid and apply B3/S23.
    function automatic grid_t ref_next(input grid_t g);
        grid_t n;
        int    cnt;
        n = '0;
        for (int r = 0; r < S; r++) begin
            for (int c = 0; c < S; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            cnt += int'(g[((r + dr + S) % S) * S + ((c + dc + S) % S)]);
                n[r * S + c] = (cnt == 3) || (cnt == 2 && g[r * S + c]);
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input grid_t act, input grid_t req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // All driving happens 1 time unit after a rising edge.
    task automatic do_load(input grid_t seed);
        bus.load = 1'b1;
        bus.d    = seed;
        @(posedge clk); #1;
        bus.load = 1'b0;
    endtask

    task automatic evolve(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    vec_t  vecs[6];
    grid_t model;
    grid_t seed;
    grid_t blink_h;
    grid_t blink_v;

    initial begin
        bus.load = 1'b0;
        bus.d    = '0;

        blink_h = mk(84, 85, 86, -1, -1);
        blink_v = mk(69, 85, 101, -1, -1);

        vecs[0] = '{"blinker_1gen",    blink_h, 1,  blink_v};
        vecs[1] = '{"blinker_2gen",    blink_h, 2,  blink_h};
        vecs[2] = '{"wrap_blinker",    mk(15, 0, 1, -1, -1), 1, mk(240, 0, 16, -1, -1)};
        vecs[3] = '{"block_still",     mk(0, 1, 16, 17, -1), 16, mk(0, 1, 16, 17, -1)};
        vecs[4] = '{"corner_block",    mk(0, 15, 240, 255, -1), 16, mk(0, 15, 240, 255, -1)};
        vecs[5] = '{"glider_64",       mk(1, 18, 32, 33, 34), 64, mk(1, 18, 32, 33, 34)};

        // Power-on reset
        areset = 1'b1;
        #2;
        chk("reset_q", bus.q, '0);
`ifdef GOL_STABLE_EN
        chk1("reset_stable", bus.stable, 1'b0);
`endif
        @(posedge clk); #1;
        areset = 1'b0;
        evolve(3);
        chk("idle_zero", bus.q, '0);

        // Table of known patterns
        for (int i = 0; i < 6; i++) begin
            do_load(vecs[i].seed);
            chk({vecs[i].name, "_load"}, bus.q, vecs[i].seed);
            evolve(vecs[i].gens);
            chk(vecs[i].name, bus.q, vecs[i].expected);
        end

`ifdef GOL_STABLE_EN
        do_load(mk(0, 1, 16, 17, -1));
        chk1("stable_after_load", bus.stable, 1'b0);
        evolve(2);
        chk1("stable_block", bus.stable, 1'b1);
        do_load(blink_h);
        chk1("stable_cleared_by_load", bus.stable, 1'b0);
        evolve(2);
        chk1("stable_blinker", bus.stable, 1'b0);
`endif

        // Load priority: held load keeps recapturing d
        bus.load = 1'b1;
        bus.d    = blink_h;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("load_hold", bus.q, blink_h);
        end
        bus.load = 1'b0;
        evolve(1);
        chk("load_release_1", bus.q, blink_v);
        evolve(1);
        chk("load_release_2", bus.q, blink_h);

        // Random soups against the reference model
        for (int t = 0; t < 6; t++) begin
            for (int w = 0; w < W / 32; w++) seed[w * 32 +: 32] = $urandom;
            do_load(seed);
            model = seed;
            for (int g = 0; g < 10; g++) begin
                evolve(1);
                model = ref_next(model);
                chk($sformatf("random_t%0d_g%0d", t, g), bus.q, model);
            end
        end

        // Asynchronous reset mid-run, then held with load asserted
        for (int w = 0; w < W / 32; w++) seed[w * 32 +: 32] = $urandom | 32'h1;
        do_load(seed);
        evolve(2);
        #2 areset = 1'b1;
        #1;
        chk("async_reset", bus.q, '0);
        bus.load = 1'b1;
        bus.d    = blink_h;
        evolve(2);
        chk("reset_blocks_load", bus.q, '0);
        #1 areset = 1'b0;
        bus.load = 1'b0;
        evolve(4);
        chk("post_reset_idle", bus.q, '0);
`ifdef GOL_STABLE_EN
        areset = 1'b1;
        #1;
        chk1("stable_reset_mid", bus.stable, 1'b0);
        areset = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
